hazard_stall_controller: RTL and testbench
==========================================

# hazard_stall_controller

Pipeline sequencing controller for the 5-stage MIPS32 core: owns the PC, IF/ID, ID/EX and EX/MEM enables and flushes. Detects load-use hazards that forwarding cannot resolve, flushes younger instructions on a taken branch, and freezes the pipeline while data memory has not acknowledged an access. A timeout error state traps runaway memory waits. Sits beside the forwarding logic, between the hazard sources and the pipeline registers.

## Interface
- MEM_WAIT_MAX, 15: MEM_WAIT cycles allowed without mem_ack before entering ERROR; legal range 1..255.
- clk  input  1  pipeline clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- IDEXMemRead  input  1  instruction in EX is a load
- IDEXRt  input  5  load destination register
- IFIDRs  input  5  source Rs of instruction in ID
- IFIDRt  input  5  source Rt of instruction in ID
- IFIDUsesRt  input  1  ID instruction reads Rt as a source
- BranchTaken  input  1  branch resolved taken in EX
- MemReq  input  1  EX/MEM stage is accessing data memory this cycle
- MemAck  input  1  data memory completes the access this cycle
- PCWrite  output  1  PC update enable
- IFIDWrite  output  1  IF/ID register enable
- IDEXWrite  output  1  ID/EX register enable
- EXMEMHold  output  1  hold EX/MEM and MEM/WB contents
- IDEXBubble  output  1  zero control fields loaded into ID/EX
- IFIDFlush  output  1  clear IF/ID to NOP
- MemTimeout  output  1  registered, sticky until rst
- StallCount  output  32  stall-cycle counter (see Configuration)

## Operation
- States: RUN, MEM_WAIT, ERROR (2-bit register, reset RUN). Wait counter wait_cnt is 8 bits, reset 0.
- Freeze = (RUN & MemReq & ~MemAck) | (MEM_WAIT & ~MemAck) | ERROR. During freeze: PCWrite = IFIDWrite = IDEXWrite = 0, EXMEMHold = 1, IDEXBubble = IFIDFlush = 0.
- LoadUse = IDEXMemRead & (IDEXRt != 0) & ((IDEXRt == IFIDRs) | (IFIDUsesRt & IDEXRt == IFIDRt)).
- Priority: Freeze > BranchTaken > LoadUse > normal.
- BranchTaken (no freeze): IFIDFlush = 1, IDEXBubble = 1, all enables 1, EXMEMHold = 0. Any coincident LoadUse is ignored because the ID instruction is discarded.
- LoadUse (no freeze, no branch): PCWrite = IFIDWrite = 0, IDEXWrite = 1, IDEXBubble = 1. Exactly one stall cycle, because the bubble clears IDEXMemRead on the next cycle.
- Normal: all enables 1, all flush/bubble/hold outputs 0.
- Transitions:
  - RUN to MEM_WAIT when MemReq & ~MemAck; wait_cnt loads 1.
  - MEM_WAIT to RUN on MemAck; the pipeline advances in that same cycle.
  - In MEM_WAIT with ~MemAck: if wait_cnt == MEM_WAIT_MAX, go to ERROR and set MemTimeout; otherwise increment wait_cnt.
  - ERROR is exited only by rst.
- MemReq & MemAck in the same cycle in RUN: no freeze, no state change.
- BranchTaken or LoadUse asserted during a freeze is not acted on. Inputs are re-evaluated when the freeze releases, because the stage contents were held.

## Timing
- All control outputs are combinational from state and inputs, with zero-cycle latency to the pipeline-register enables. MemTimeout and StallCount are registered.
- While rst is high, outputs are forced to: PCWrite = IFIDWrite = IDEXWrite = 0, IDEXBubble = 1, IFIDFlush = 1, EXMEMHold = 0.
- Register reset values: state RUN, wait_cnt 0, MemTimeout 0, StallCount 0.
- An unacknowledged access freezes MEM_WAIT_MAX + 1 cycles (the RUN detection cycle plus MEM_WAIT_MAX cycles in MEM_WAIT). ERROR begins on the following edge.
- rst asserted mid-wait or in ERROR returns the block to RUN on the next edge. No partial access state is retained.

## Configuration
- PERF_STALL_CNT_EN defined: StallCount increments on every non-reset cycle with PCWrite == 0. It saturates at 0xFFFFFFFF and clears on rst.
- PERF_STALL_CNT_EN undefined: StallCount is tied to 0 and no counter logic is built. All other behaviour is identical.

## Test plan
- Load-use: lw $5 in EX (IDEXMemRead = 1, IDEXRt = 5), IFIDRs = 5. Expect one cycle of PCWrite = 0, IFIDWrite = 0, IDEXBubble = 1, then normal. StallCount = 1 with the macro defined.
- $zero and Rt filtering:
  - IDEXRt = 0 with IFIDRs = 0: no stall.
  - IDEXRt = 7, IFIDRt = 7, IFIDUsesRt = 0: no stall.
  - IDEXRt = 7, IFIDRt = 7, IFIDUsesRt = 1: stall.
- BranchTaken = 1 together with LoadUse: IFIDFlush = 1, IDEXBubble = 1, PCWrite = 1, no stall cycle.
- MemReq = 1 with MemAck arriving 3 cycles later: freeze for 3 cycles (RUN, then MEM_WAIT with wait_cnt = 1, 2). Release in the ack cycle and return to RUN. MemTimeout stays 0.
- MEM_WAIT_MAX = 4, MemReq held, MemAck never asserted: freeze for 5 cycles, ERROR from cycle 6 with MemTimeout = 1 held. Asserting rst for 1 cycle returns to RUN with MemTimeout = 0.
- rst asserted in cycle 2 of a memory wait: next cycle state is RUN, wait_cnt = 0, StallCount = 0.

Source files
------------

// File: rtl/hazard_stall_controller_if.sv
// Pipeline hazard/sequencing bundle between the hazard sources, the pipeline registers and the controller.
// "slave" is the controller side; "master" is the pipeline/hazard-source side.
interface hazard_stall_controller_if;
    logic        IDEXMemRead;
    logic [4:0]  IDEXRt;
    logic [4:0]  IFIDRs;
    logic [4:0]  IFIDRt;
    logic        IFIDUsesRt;
    logic        BranchTaken;
    logic        MemReq;
    logic        MemAck;
    logic        PCWrite;
    logic        IFIDWrite;
    logic        IDEXWrite;
    logic        EXMEMHold;
    logic        IDEXBubble;
    logic        IFIDFlush;
    logic        MemTimeout;
    logic [31:0] StallCount;

    modport master (
        output IDEXMemRead, IDEXRt, IFIDRs, IFIDRt, IFIDUsesRt, BranchTaken, MemReq, MemAck,
        input  PCWrite, IFIDWrite, IDEXWrite, EXMEMHold, IDEXBubble, IFIDFlush, MemTimeout, StallCount
    );

    modport slave (
        input  IDEXMemRead, IDEXRt, IFIDRs, IFIDRt, IFIDUsesRt, BranchTaken, MemReq, MemAck,
        output PCWrite, IFIDWrite, IDEXWrite, EXMEMHold, IDEXBubble, IFIDFlush, MemTimeout, StallCount
    );
endinterface

// File: rtl/hazard_stall_controller.sv
// Purpose: PC/IF-ID/ID-EX/EX-MEM enables and flushes for load-use, taken-branch and data-memory waits.
// Latency: control outputs are combinational (0 cycles); MemTimeout/StallCount registered.
// Backpressure: an unacknowledged MemReq freezes the whole pipe; MEM_WAIT_MAX overrun traps in ERROR until rst.
// Optional stall counter built only when PERF_STALL_CNT_EN is defined.
module hazard_stall_controller #(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic                    clk,
    input  logic                    rst,
    hazard_stall_controller_if.slave bus
);
    localparam logic [1:0] RUN      = 2'd0;
    localparam logic [1:0] MEM_WAIT = 2'd1;
    localparam logic [1:0] ERROR    = 2'd2;
    localparam logic [7:0] WAIT_MAX = 8'(MEM_WAIT_MAX);

    logic [1:0] r_state;
    logic [7:0] r_wait_cnt;
    logic       r_mem_timeout;

    logic w_freeze;
    logic w_load_use;
    logic w_pc_write;
    logic w_ifid_write;
    logic w_idex_write;
    logic w_exmem_hold;
    logic w_idex_bubble;
    logic w_ifid_flush;

    assign w_freeze = ((r_state == RUN) && bus.MemReq && !bus.MemAck)
                    || ((r_state == MEM_WAIT) && !bus.MemAck)
                    || (r_state == ERROR);

    assign w_load_use = bus.IDEXMemRead && (bus.IDEXRt != 5'd0)
                      && ((bus.IDEXRt == bus.IFIDRs)
                          || (bus.IFIDUsesRt && (bus.IDEXRt == bus.IFIDRt)));

    always_comb begin
        w_pc_write    = 1'b1;
        w_ifid_write  = 1'b1;
        w_idex_write  = 1'b1;
        w_exmem_hold  = 1'b0;
        w_idex_bubble = 1'b0;
        w_ifid_flush  = 1'b0;
        if (rst) begin
            w_pc_write    = 1'b0;
            w_ifid_write  = 1'b0;
            w_idex_write  = 1'b0;
            w_idex_bubble = 1'b1;
            w_ifid_flush  = 1'b1;
        end else if (w_freeze) begin
            w_pc_write   = 1'b0;
            w_ifid_write = 1'b0;
            w_idex_write = 1'b0;
            w_exmem_hold = 1'b1;
        end else if (bus.BranchTaken) begin
            // the ID instruction is discarded, so any load-use on it is moot
            w_idex_bubble = 1'b1;
            w_ifid_flush  = 1'b1;
        end else if (w_load_use) begin
            w_pc_write    = 1'b0;
            w_ifid_write  = 1'b0;
            w_idex_bubble = 1'b1;
        end
    end

    assign bus.PCWrite    = w_pc_write;
    assign bus.IFIDWrite  = w_ifid_write;
    assign bus.IDEXWrite  = w_idex_write;
    assign bus.EXMEMHold  = w_exmem_hold;
    assign bus.IDEXBubble = w_idex_bubble;
    assign bus.IFIDFlush  = w_ifid_flush;
    assign bus.MemTimeout = r_mem_timeout;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= RUN;
            r_wait_cnt    <= 8'd0;
            r_mem_timeout <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    if (bus.MemReq && !bus.MemAck) begin
                        r_state    <= MEM_WAIT;
                        r_wait_cnt <= 8'd1;
                    end
                end
                MEM_WAIT: begin
                    if (bus.MemAck) begin
                        r_state    <= RUN;
                        r_wait_cnt <= 8'd0;
                    end else if (r_wait_cnt == WAIT_MAX) begin
                        r_state       <= ERROR;
                        r_mem_timeout <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end
                ERROR: begin
                    r_state <= ERROR;
                end
                default: begin
                    r_state    <= RUN;
                    r_wait_cnt <= 8'd0;
                end
            endcase
        end
    end

`ifdef PERF_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= 32'd0;
        end else if (!w_pc_write && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign bus.StallCount = r_stall_cnt;
`else
    assign bus.StallCount = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Bench for hazard_stall_controller: vector table for the combinational hazard priority, plus hand sequences
// for memory waits, timeout trap and mid-wait reset; expected values flow through a scoreboard queue.
module tb_hazard_stall_controller;
    localparam int WAIT_MAX = 4;
`ifdef PERF_STALL_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    // {PCWrite, IFIDWrite, IDEXWrite, EXMEMHold, IDEXBubble, IFIDFlush}
    localparam logic [5:0] C_NORM  = 6'b111000;
    localparam logic [5:0] C_STALL = 6'b001010;
    localparam logic [5:0] C_BR    = 6'b111011;
    localparam logic [5:0] C_FRZ   = 6'b000100;
    localparam logic [5:0] C_RST   = 6'b000011;

    typedef struct packed {
        logic       rst;
        logic       mr;
        logic [4:0] idexrt;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       ur;
        logic       br;
        logic       mq;
        logic       ma;
    } in_t;

    typedef struct {
        string      nm;
        in_t        v;
        logic [5:0] ctl;
    } vec_t;

    typedef struct {
        string      nm;
        logic [5:0] ctl;
        logic       tmo;
        logic       rst;
    } exp_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   exp_stall;
    exp_t exp_q[$];
    vec_t tbl[$];

    hazard_stall_controller_if ifc();

    hazard_stall_controller #(.MEM_WAIT_MAX(WAIT_MAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic in_t mk(logic r, logic mr, logic [4:0] idexrt, logic [4:0] rs, logic [4:0] rt,
                               logic ur, logic br, logic mq, logic ma);
        in_t v;
        v.rst = r; v.mr = mr; v.idexrt = idexrt; v.rs = rs; v.rt = rt;
        v.ur = ur; v.br = br; v.mq = mq; v.ma = ma;
        return v;
    endfunction

    task automatic apply(input in_t v);
        rst             = v.rst;
        ifc.IDEXMemRead = v.mr;
        ifc.IDEXRt      = v.idexrt;
        ifc.IFIDRs      = v.rs;
        ifc.IFIDRt      = v.rt;
        ifc.IFIDUsesRt  = v.ur;
        ifc.BranchTaken = v.br;
        ifc.MemReq      = v.mq;
        ifc.MemAck      = v.ma;
    endtask

    task automatic check_out();
        exp_t        e;
        logic [5:0]  got;
        logic [31:0] want_cnt;
        if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL scoreboard_empty: got 0 entries want 1");
            return;
        end
        e   = exp_q.pop_front();
        got = {ifc.PCWrite, ifc.IFIDWrite, ifc.IDEXWrite, ifc.EXMEMHold, ifc.IDEXBubble, ifc.IFIDFlush};
        total++;
        if (got !== e.ctl) begin
            bad++;
            $display("FAIL %s.ctl: got %b want %b", e.nm, got, e.ctl);
        end
        total++;
        if (ifc.MemTimeout !== e.tmo) begin
            bad++;
            $display("FAIL %s.timeout: got %b want %b", e.nm, ifc.MemTimeout, e.tmo);
        end
        want_cnt = CNT_EN ? 32'(exp_stall) : 32'd0;
        total++;
        if (ifc.StallCount !== want_cnt) begin
            bad++;
            $display("FAIL %s.stallcnt: got %0d want %0d", e.nm, ifc.StallCount, want_cnt);
        end
        if (e.rst) exp_stall = 0;
        else if (!e.ctl[5]) exp_stall++;
    endtask

    task automatic step(input string nm, input in_t v, input logic [5:0] ctl, input logic tmo);
        exp_t e;
        @(posedge clk);
        #1;
        apply(v);
        e.nm = nm; e.ctl = ctl; e.tmo = tmo; e.rst = v.rst;
        exp_q.push_back(e);
        @(negedge clk);
        check_out();
    endtask

    in_t idle;

    initial begin
        total = 0;
        bad = 0;
        exp_stall = 0;
        idle = mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
        apply(mk(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0));
        repeat (2) @(posedge clk);

        step("reset", mk(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0), C_RST, 1'b0);

        tbl.push_back('{"idle",        idle,                                          C_NORM});
        tbl.push_back('{"lu_rs",       mk(0, 1, 5'd5,  5'd5,  5'd0,  0, 0, 0, 0), C_STALL});
        tbl.push_back('{"zero_reg",    mk(0, 1, 5'd0,  5'd0,  5'd0,  1, 0, 0, 0), C_NORM});
        tbl.push_back('{"rt_unused",   mk(0, 1, 5'd7,  5'd3,  5'd7,  0, 0, 0, 0), C_NORM});
        tbl.push_back('{"rt_used",     mk(0, 1, 5'd7,  5'd3,  5'd7,  1, 0, 0, 0), C_STALL});
        tbl.push_back('{"no_load",     mk(0, 0, 5'd5,  5'd5,  5'd5,  1, 0, 0, 0), C_NORM});
        tbl.push_back('{"br_lu",       mk(0, 1, 5'd5,  5'd5,  5'd0,  0, 1, 0, 0), C_BR});
        tbl.push_back('{"br_only",     mk(0, 0, 5'd0,  5'd0,  5'd0,  0, 1, 0, 0), C_BR});
        tbl.push_back('{"req_ack",     mk(0, 0, 5'd0,  5'd0,  5'd0,  0, 0, 1, 1), C_NORM});
        tbl.push_back('{"after_ack",   idle,                                          C_NORM});
        tbl.push_back('{"ack_only",    mk(0, 0, 5'd0,  5'd0,  5'd0,  0, 0, 0, 1), C_NORM});
        tbl.push_back('{"lu_mismatch", mk(0, 1, 5'd9,  5'd8,  5'd9,  0, 0, 0, 0), C_NORM});
        tbl.push_back('{"lu_r31",      mk(0, 1, 5'd31, 5'd31, 5'd31, 1, 0, 0, 0), C_STALL});
        tbl.push_back('{"req_lu",      mk(0, 1, 5'd5,  5'd5,  5'd0,  0, 1, 1, 0), C_FRZ});
        tbl.push_back('{"req_lu_ack",  mk(0, 1, 5'd5,  5'd5,  5'd0,  0, 0, 0, 1), C_STALL});
        for (int i = 0; i < tbl.size(); i++) step(tbl[i].nm, tbl[i].v, tbl[i].ctl, 1'b0);

        // load-use: one stall, then the bubble drops IDEXMemRead
        step("lu_seq0", mk(0, 1, 5'd5, 5'd5, 5'd0, 0, 0, 0, 0), C_STALL, 1'b0);
        step("lu_seq1", mk(0, 0, 5'd5, 5'd5, 5'd0, 0, 0, 0, 0), C_NORM,  1'b0);

        // ack after 3 frozen cycles; branch during freeze ignored, acted on at release
        step("ack_w0", mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0), C_FRZ, 1'b0);
        step("ack_w1", mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 1, 0), C_FRZ, 1'b0);
        step("ack_w2", mk(0, 1, 5'd5, 5'd5, 5'd0, 0, 0, 1, 0), C_FRZ, 1'b0);
        step("ack_rl", mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 1, 1), C_BR,  1'b0);
        step("ack_run", idle, C_NORM, 1'b0);

        // timeout: WAIT_MAX+1 frozen cycles, then ERROR with sticky MemTimeout
        for (int i = 0; i <= WAIT_MAX; i++)
            step($sformatf("tmo_w%0d", i), mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0), C_FRZ, 1'b0);
        step("tmo_err0", mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0), C_FRZ, 1'b1);
        step("tmo_err1", mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0), C_FRZ, 1'b1);
        step("tmo_err2", mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1), C_FRZ, 1'b1);
        step("tmo_rst",  mk(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0), C_RST, 1'b1);
        step("tmo_run",  idle, C_NORM, 1'b0);

        // reset in the second cycle of a wait drops the wait entirely
        step("mid_w0",  mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0), C_FRZ, 1'b0);
        step("mid_w1",  mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0), C_FRZ, 1'b0);
        step("mid_rst", mk(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0), C_RST, 1'b0);
        step("mid_run", idle, C_NORM, 1'b0);
        step("mid_run2", mk(0, 1, 5'd4, 5'd4, 5'd0, 0, 0, 0, 0), C_STALL, 1'b0);
        step("mid_run3", idle, C_NORM, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
